alu_issue: RTL and testbench

//  Upstream issue stage for alu. Holds an NREG x 16 register file, accepts one

---
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_issue.sv | 151 +++++++++++++++
 tb/tb_alu_issue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
//==============================================================================
// Module      : alu_issue_if
// Description : Instruction handshake and alu operand/result bundle between
//               the issue stage (slave) and its host plus alu (master).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ins;
    logic [15:0] alu_result;
    logic [15:0] alu_hi;
    logic        done;

    // Host/alu side: issues instructions, returns alu results.
    modport master (
        output in_valid, instr, alu_result, alu_hi,
        input  in_ready, alu_a, alu_b, alu_ins, done
    );

    // Issue stage side.
    modport slave (
        input  in_valid, instr, alu_result, alu_hi,
        output in_ready, alu_a, alu_b, alu_ins, done
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
//==============================================================================
// Module      : alu_issue
// Description : Single-issue blocking front end for the alu. Holds an
//               NREG x 16 register file, launches one instruction at a time,
//               waits ALU_LAT cycles and writes the result back (lo to rd,
//               hi to rd+1 for the multiply opcode).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_issue #(
    parameter int          NREG    = 8,
    parameter int          ALU_LAT = 1,
    parameter logic [3:0]  MUL_OP  = 4'h2,
    localparam int         AW      = $clog2(NREG)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_issue_if.slave         bus,
    input  wire logic          ld_en,
    input  wire logic [AW-1:0] ld_addr,
    input  wire logic [15:0]   ld_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic [15:0]        rd_data
);

    localparam logic [3:0] c_LAT_M1 = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WB_HI = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_rd;
    logic [3:0]      r_op;
    logic [15:0]     r_alu_a;
    logic [15:0]     r_alu_b;
    logic [3:0]      r_alu_ins;
    logic            r_done;
    logic [15:0]     r_regs [NREG];

    logic            w_accept;
    logic            w_wb_lo;
    logic            w_wb_hi;
    logic            w_done_nxt;
    logic [AW-1:0]   w_rd_hi;
    logic [AW-1:0]   w_ra;
    logic [AW-1:0]   w_rb;
    logic            w_unused_instr;

    // Register fields only use their low AW bits; the rest are don't-care.
    assign w_ra           = bus.instr[4 +: AW];
    assign w_rb           = bus.instr[0 +: AW];
    assign w_unused_instr = ^bus.instr;
    assign w_rd_hi        = r_rd + 1'b1;

    assign bus.in_ready = (r_state == IDLE);
    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_ins  = r_alu_ins;
    assign bus.done     = r_done;
    assign rd_data      = r_regs[rd_addr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and writeback strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wb_lo     = 1'b0;
        w_wb_hi     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_wb_lo     = 1'b1;
                    w_state_nxt = (r_op == MUL_OP) ? WB_HI : IDLE;
                end
            end
            WB_HI: begin
                w_wb_hi     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_done_nxt = (w_wb_lo && (r_op != MUL_OP)) || w_wb_hi;
    end

    // Operand launch, wait counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 4'd0;
            r_rd      <= '0;
            r_op      <= 4'd0;
            r_alu_a   <= 16'd0;
            r_alu_b   <= 16'd0;
            r_alu_ins <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_alu_a   <= r_regs[w_ra];
                r_alu_b   <= r_regs[w_rb];
                r_alu_ins <= bus.instr[15:12];
                r_op      <= bus.instr[15:12];
                r_rd      <= bus.instr[8 +: AW];
                r_cnt     <= c_LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Register file: host load first so a same-edge writeback overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 16'd0;
            end
        end else begin
            if (ld_en) begin
                r_regs[ld_addr] <= ld_data;
            end
            if (w_wb_lo) begin
                r_regs[r_rd] <= bus.alu_result;
            end
            if (w_wb_hi) begin
                r_regs[w_rd_hi] <= bus.alu_hi;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
//==============================================================================
// Module      : tb_alu_issue
// Description : Directed self-checking bench for alu_issue; one instance with
//               ALU_LAT=1 and one with ALU_LAT=3, each fed by a small alu model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data1;
    logic [15:0] rd_data3;

    int n_cmp;
    int n_err;

    alu_issue_if bus1 ();
    alu_issue_if bus3 ();

    alu_issue #(.NREG(8), .ALU_LAT(1), .MUL_OP(4'h2)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    alu_issue #(.NREG(8), .ALU_LAT(3), .MUL_OP(4'h2)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus3),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference alu: 0 add, 1 sub, 2 multiply {hi,lo}, 3 xor.
    function automatic logic [31:0] alu_full(input logic [3:0] ins,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        case (ins)
            4'h0:    return {16'h0, 16'(a + b)};
            4'h1:    return {16'h0, 16'(a - b)};
            4'h2:    return 32'(a) * 32'(b);
            4'h3:    return {16'h0, a ^ b};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        {bus1.alu_hi, bus1.alu_result} = alu_full(bus1.alu_ins, bus1.alu_a, bus1.alu_b);
        {bus3.alu_hi, bus3.alu_result} = alu_full(bus3.alu_ins, bus3.alu_a, bus3.alu_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic read1(input string tag, input logic [2:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data1, exp);
    endtask

    logic [15:0] prog [3];
    int          idx;
    int          dones;
    logic        acc;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        rd_addr = '0;
        bus1.in_valid = 1'b0;
        bus1.instr    = '0;
        bus3.in_valid = 1'b0;
        bus3.instr    = '0;

        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_ready1", bus1.in_ready, 1);
        check("rst_done1",  bus1.done, 0);
        check("rst_alu_a1", bus1.alu_a, 0);
        check("rst_ins1",   bus1.alu_ins, 0);
        rst_n = 1'b1;

        // Reset mid-WAIT on the ALU_LAT=3 instance.
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0006);
        bus3.instr    = 16'h0312;
        bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        check("t1_busy3",  bus3.in_ready, 0);
        check("t1_alu_a3", bus3.alu_a, 16'h0005);
        tick();
        rst_n = 1'b0;
        #1;
        check("t1_ready3", bus3.in_ready, 1);
        check("t1_done3",  bus3.done, 0);
        check("t1_alu_a3r", bus3.alu_a, 0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            check("t1_reg3", rd_data3, 0);
            check("t1_reg1", rd_data1, 0);
        end
        tick();
        tick();
        tick();
        tick();
        check("t1_nodone_rst", bus3.done, 0);
        rst_n = 1'b1;
        tick();
        check("t1_nodone_rel", bus3.done, 0);
        rd_addr = 3'd3;
        #1;
        check("t1_no_wb", rd_data3, 0);

        // ADD path, ALU_LAT=1.
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        check("t2_ready_pre", bus1.in_ready, 1);
        bus1.instr    = 16'h0312;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("t2_done_c1", bus1.done, 0);
        check("t2_busy",    bus1.in_ready, 0);
        check("t2_alu_a",   bus1.alu_a, 16'h0003);
        check("t2_alu_b",   bus1.alu_b, 16'h0004);
        check("t2_alu_ins", bus1.alu_ins, 0);
        tick();
        check("t2_done",    bus1.done, 1);
        check("t2_ready",   bus1.in_ready, 1);
        read1("t2_r3", 3'd3, 16'h0007);
        tick();
        check("t2_done_off", bus1.done, 0);

        // MUL path with rd+1 wrap to r0.
        load(3'd1, 16'h1234);
        load(3'd2, 16'h0100);
        bus1.instr    = 16'h2712;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("t3_done_c1", bus1.done, 0);
        tick();
        check("t3_done_c2", bus1.done, 0);
        check("t3_busy_hi", bus1.in_ready, 0);
        read1("t3_r7", 3'd7, 16'h3400);
        tick();
        check("t3_done",    bus1.done, 1);
        tick();
        check("t3_done_off", bus1.done, 0);
        read1("t3_r0", 3'd0, 16'h0012);

        // Host load colliding with writeback.
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        bus1.instr    = 16'h0312;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 3'd3;
        ld_data = 16'hBEEF;
        tick();
        ld_en = 1'b0;
        read1("t4_r3_wb_wins", 3'd3, 16'h0007);
        bus1.instr    = 16'h0312;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 3'd4;
        ld_data = 16'hBEEF;
        tick();
        ld_en = 1'b0;
        read1("t4_r4_ld", 3'd4, 16'hBEEF);
        read1("t4_r3_keep", 3'd3, 16'h0007);
        tick();

        // Back-to-back with in_valid held high.
        prog[0] = 16'h0512;   // r5 = r1 + r2 = 7
        prog[1] = 16'h1621;   // r6 = r2 - r1 = 1
        prog[2] = 16'h3112;   // r1 = r1 ^ r2 = 7
        idx   = 0;
        dones = 0;
        bus1.instr    = prog[0];
        bus1.in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (idx == 3 && dones == 3) break;
            acc = bus1.in_ready && bus1.in_valid;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) bus1.instr = prog[idx];
                else bus1.in_valid = 1'b0;
            end
            if (bus1.done) dones++;
        end
        bus1.in_valid = 1'b0;
        check("t5_accepts", 32'(idx), 3);
        check("t5_dones",   32'(dones), 3);
        read1("t5_r5", 3'd5, 16'h0007);
        read1("t5_r6", 3'd6, 16'h0001);
        read1("t5_r1", 3'd1, 16'h0007);
        tick();

        // ALU_LAT=3: ignored in_valid during WAIT, operands held.
        load(3'd1, 16'h0010);
        load(3'd2, 16'h0005);
        bus3.instr    = 16'h1412;
        bus3.in_valid = 1'b1;
        tick();
        bus3.instr    = 16'h0000;
        check("t6_a0", bus3.alu_a, 16'h0010);
        check("t6_b0", bus3.alu_b, 16'h0005);
        check("t6_i0", bus3.alu_ins, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t6_a_hold", bus3.alu_a, 16'h0010);
            check("t6_b_hold", bus3.alu_b, 16'h0005);
            check("t6_i_hold", bus3.alu_ins, 1);
            check("t6_busy",   bus3.in_ready, 0);
            check("t6_nodone", bus3.done, 0);
        end
        bus3.in_valid = 1'b0;
        tick();
        check("t6_done",   bus3.done, 1);
        check("t6_a_hold3", bus3.alu_a, 16'h0010);
        rd_addr = 3'd4;
        #1;
        check("t6_r4", rd_data3, 16'h000B);
        tick();
        check("t6_done_off", bus3.done, 0);
        check("t6_idle",     bus3.in_ready, 1);
        check("t6_no_ghost", bus3.alu_a, 16'h0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
